// File: rtl/adc_cassette_slicer_pkg.sv
// adc_cassette_slicer_pkg: shared types and sizing for the cassette ADC slicer.
package adc_cassette_slicer_pkg;

    localparam int ADC_W = 12;

    typedef enum logic [1:0] {IDLE, READ, UPDATE, DECIDE} state_t;

    function automatic int total_w(input int avg_log2);
        return ADC_W + avg_log2;
    endfunction

endpackage

// File: rtl/adc_cassette_slicer_ram.sv
// adc_cassette_slicer_ram: simple dual-port sample history RAM with registered read.
module adc_cassette_slicer_ram #(
    parameter int AW = 9,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/adc_cassette_slicer.sv
// adc_cassette_slicer: running-average hysteresis slicer turning ADC samples into the cassette bit.
// Optional flip deglitching is enabled with ADC_CASSETTE_SLICER_DEGLITCH_EN.
module adc_cassette_slicer
    import adc_cassette_slicer_pkg::*;
#(
    parameter int AVG_LOG2 = 9,
    parameter int HYST     = 100,
    parameter int DEGLITCH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_sync,
    input  logic             enable,
    output logic             cas_bit,
    output logic [ADC_W-1:0] avg,
    output logic             primed,
    output logic             edge_stb
);

    localparam int TW = total_w(AVG_LOG2);
    localparam int DEPTH = 2**AVG_LOG2;
    localparam logic signed [13:0] HYST_S = 14'(HYST);

    state_t                r_state;
    logic                  r_sync_d;
    logic [ADC_W-1:0]      r_smp;
    logic [ADC_W-1:0]      r_pend_data;
    logic                  r_pend;
    logic [TW-1:0]         r_total;
    logic [AVG_LOG2:0]     r_fill;
    logic [AVG_LOG2-1:0]   r_wr_ptr;
    logic                  r_bit;
    logic [ADC_W-1:0]      r_avg;
    logic                  r_primed;
    logic                  r_cas;
    logic                  r_edge;
    logic [ADC_W-1:0]      w_rd_data;
    logic [ADC_W-1:0]      w_old;
    logic [ADC_W-1:0]      w_avg;
    logic                  w_new;
    logic                  w_full;
    logic                  w_decide;
    logic signed [13:0]    w_smp_s;
    logic signed [13:0]    w_lo;
    logic signed [13:0]    w_hi;
    logic                  w_below;
    logic                  w_above;
    logic                  w_bit_nxt;
    logic                  w_cas_nxt;

    adc_cassette_slicer_ram #(.AW(AVG_LOG2), .DW(ADC_W)) u_ram (
        .clk       (clk),
        .i_wr_en   (r_state == UPDATE),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (r_smp),
        .i_rd_addr (r_wr_ptr),
        .o_rd_data (w_rd_data)
    );

    // Thresholds are evaluated against the freshly updated total, which is what DECIDE latches as avg.
    always_comb begin
        w_new    = adc_sync ^ r_sync_d;
        w_old    = r_primed ? w_rd_data : '0;
        w_avg    = r_total[TW-1:AVG_LOG2];
        w_full   = r_fill == (AVG_LOG2+1)'(DEPTH);
        w_decide = (r_state == DECIDE) && w_full;
        w_smp_s  = $signed({2'b00, r_smp});
        w_lo     = $signed({2'b00, w_avg}) - HYST_S;
        w_hi     = $signed({2'b00, w_avg}) + HYST_S;
        w_below  = !w_lo[13] && (w_smp_s < w_lo);
        w_above  = (w_hi <= 14'sd4095) && (w_smp_s > w_hi);
    end

`ifdef ADC_CASSETTE_SLICER_DEGLITCH_EN
    logic [7:0] r_dg;
    logic       w_flip;
    logic       w_dg_hit;

    always_comb begin
        w_flip    = (w_below && !r_bit) || (w_above && r_bit);
        w_dg_hit  = w_flip && (32'(r_dg) + 32'd1 >= 32'(DEGLITCH));
        w_bit_nxt = (w_decide && w_dg_hit) ? ~r_bit : r_bit;
        w_cas_nxt = w_bit_nxt & enable;
    end

    always_ff @(posedge clk) begin
        if (reset) r_dg <= '0;
        else if (w_decide) r_dg <= (w_flip && !w_dg_hit) ? r_dg + 8'd1 : 8'd0;
    end
`else
    always_comb begin
        w_bit_nxt = (w_decide && (w_below || w_above)) ? w_below : r_bit;
        w_cas_nxt = w_bit_nxt & enable;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_d    <= adc_sync;
            r_state     <= IDLE;
            r_smp       <= '0;
            r_pend      <= 1'b0;
            r_pend_data <= '0;
            r_total     <= '0;
            r_fill      <= '0;
            r_wr_ptr    <= '0;
            r_bit       <= 1'b0;
            r_avg       <= '0;
            r_primed    <= 1'b0;
            r_cas       <= 1'b0;
            r_edge      <= 1'b0;
        end else begin
            r_sync_d <= adc_sync;
            r_bit    <= w_bit_nxt;
            r_cas    <= w_cas_nxt;
            r_edge   <= w_cas_nxt ^ r_cas;
            if (w_new && (r_state == READ || r_state == UPDATE)) begin
                r_pend      <= 1'b1;
                r_pend_data <= adc_data;
            end
            case (r_state)
                IDLE: begin
                    if (w_new) begin
                        r_smp   <= adc_data;
                        r_state <= READ;
                    end
                end
                READ: r_state <= UPDATE;
                UPDATE: begin
                    r_total  <= r_total - TW'(w_old) + TW'(r_smp);
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_fill   <= w_full ? r_fill : r_fill + 1'b1;
                    r_state  <= DECIDE;
                end
                default: begin
                    r_avg    <= w_avg;
                    r_primed <= w_full;
                    r_pend   <= 1'b0;
                    r_smp    <= w_new ? adc_data : r_pend_data;
                    r_state  <= (w_new || r_pend) ? READ : IDLE;
                end
            endcase
        end
    end

    assign cas_bit  = r_cas;
    assign avg      = r_avg;
    assign primed   = r_primed;
    assign edge_stb = r_edge;

endmodule
